// File: rtl/gray_pkg.sv
// gray_pkg: shared helpers for gray-coded pointer crossings.
// Conversions work on 32-bit words; callers size-cast.
package gray_pkg;

  localparam bit MODE_WR = 1'b1;
  localparam bit MODE_RD = 1'b0;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] x
  );
    return x ^ (x >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// gray_sync_chain: multi-flop synchroniser for a gray word.
// Only safe for values that change one bit at a time.
module gray_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // shift the asynchronous word through STAGES flops
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: one side of a dual-clock FIFO pointer pair.
// Local bin/gray pointer, synchronised remote view, level/flag.
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int PTR         = 3,
  parameter int SYNC_STAGES = 2,
  parameter bit MODE        = MODE_WR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [PTR:0] rmt_gray_in,
  output logic [PTR:0] ptr_bin,
  output logic [PTR:0] ptr_gray,
  output logic [PTR:0] rmt_bin,
  output logic [PTR:0] level,
  output logic         flag,
  output logic         err
);

  localparam int PW = PTR + 1;
  localparam logic [PTR:0] FULL_LVL =
    {1'b1, {PTR{1'b0}}};

  logic [PTR:0] ptr_bin_q, ptr_bin_d;
  logic [PTR:0] ptr_gray_q, ptr_gray_d;
  logic [PTR:0] rmt_bin_q, rmt_bin_d;
  logic [PTR:0] rmt_gray_s;
  logic         err_q, err_d;
  logic [PTR:0] level_w;
  logic         flag_w;

  gray_sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rmt_gray_in),
    .q_o (rmt_gray_s)
  );

  // occupancy seen from this side; remote view lags, so pessimistic
  always_comb begin
    if (MODE == MODE_WR) begin
      level_w = ptr_bin_q - rmt_bin_q;
      flag_w  = (level_w == FULL_LVL);
    end else begin
      level_w = rmt_bin_q - ptr_bin_q;
      flag_w  = (level_w == '0);
    end
  end

  // clr beats inc; an inc against the flag only sets err
  always_comb begin
    ptr_bin_d = ptr_bin_q;
    err_d     = err_q;
    if (clr) begin
      ptr_bin_d = '0;
      err_d     = 1'b0;
    end else if (inc) begin
      if (flag_w) err_d     = 1'b1;
      else        ptr_bin_d = ptr_bin_q + 1'b1;
    end
    ptr_gray_d = PW'(bin2gray(32'(ptr_bin_d)));
    rmt_bin_d  = PW'(gray2bin(32'(rmt_gray_s)));
  end

  // gray and binary pointers move on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      rmt_bin_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      rmt_bin_q  <= rmt_bin_d;
      err_q      <= err_d;
    end
  end

  // a level beyond the depth means the peer broke the protocol
  a_level_range : assert property (
    @(posedge clk) disable iff (rst)
    level_w <= FULL_LVL
  );

  assign ptr_bin  = ptr_bin_q;
  assign ptr_gray = ptr_gray_q;
  assign rmt_bin  = rmt_bin_q;
  assign level    = level_w;
  assign flag     = flag_w;
  assign err      = err_q;

endmodule
